// File: rtl/avfcl_acc_reader.sv
// Epoch-based readout of the six AVF structure accumulators: on each epoch
// boundary the modular growth of every accumulator is streamed as a tagged record.
module avfcl_acc_reader #(
  parameter int ACC_W   = 25,
  parameter int EPOCH_W = 16,
  parameter int EIDX_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [EPOCH_W-1:0] epoch_len,
  input  logic [ACC_W-1:0]   iq_acc,
  input  logic [ACC_W-1:0]   rob_acc,
  input  logic [ACC_W-1:0]   lq_acc,
  input  logic [ACC_W-1:0]   sq_acc,
  input  logic [ACC_W-1:0]   ib_acc,
  input  logic [ACC_W-1:0]   prf_acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_id,
  output logic [ACC_W-1:0]   out_delta,
  output logic [EIDX_W-1:0]  out_epoch,
  output logic               out_last,
  output logic               overrun,
  output logic               busy
);

  localparam int         NSRC    = 6;
  localparam logic [2:0] LAST_ID = 3'd5;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             r_state, w_next_state;
  logic [EPOCH_W-1:0] r_cnt;
  logic [EIDX_W-1:0]  r_epoch_idx;
  logic [EIDX_W-1:0]  r_snap_epoch;
  logic [ACC_W-1:0]   r_prev  [NSRC];
  logic [ACC_W-1:0]   r_delta [NSRC];
  logic [2:0]         r_idx;
  logic               r_overrun;

  logic [ACC_W-1:0]   w_acc [NSRC];
  logic               w_run, w_terminal, w_handshake, w_sample;

  assign w_acc[0] = iq_acc;
  assign w_acc[1] = rob_acc;
  assign w_acc[2] = lq_acc;
  assign w_acc[3] = sq_acc;
  assign w_acc[4] = ib_acc;
  assign w_acc[5] = prf_acc;

  // >= rather than == so a shortened epoch_len ends the epoch immediately
  assign w_run       = enable && (epoch_len != '0);
  assign w_terminal  = w_run && (r_cnt >= epoch_len - EPOCH_W'(1));
  assign w_handshake = (r_state == SEND) && out_ready;
  assign w_sample    = (r_state == IDLE) && w_terminal;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_epoch_idx <= '0;
    end else if (w_terminal) begin
      r_cnt       <= '0;
      r_epoch_idx <= r_epoch_idx + EIDX_W'(1);
    end else if (w_run) begin
      r_cnt       <= r_cnt + EPOCH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_terminal) w_next_state = SEND;
      SEND:    if (out_ready && (r_idx == LAST_ID)) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: prev/delta are reset explicitly; the first delta after reset must
  // equal the raw accumulator value, so these are not left uninitialised.
  // A boundary hit during SEND leaves prev untouched, so the next delta spans
  // every dropped epoch.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSRC; i++) begin
        r_prev[i]  <= '0;
        r_delta[i] <= '0;
      end
      r_idx        <= '0;
      r_snap_epoch <= '0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_sample) begin
        for (int i = 0; i < NSRC; i++) begin
          r_delta[i] <= w_acc[i] - r_prev[i];
          r_prev[i]  <= w_acc[i];
        end
        r_idx        <= '0;
        r_snap_epoch <= r_epoch_idx;
      end else if (w_handshake) begin
        r_idx <= (r_idx == LAST_ID) ? 3'd0 : r_idx + 3'd1;
      end
      if ((r_state == SEND) && w_terminal) r_overrun <= 1'b1;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out_id    = '0;
    out_delta = '0;
    out_epoch = '0;
    out_last  = 1'b0;
    if (r_state == SEND) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_id    = r_idx;
      out_delta = r_delta[r_idx];
      out_epoch = r_snap_epoch;
      out_last  = (r_idx == LAST_ID);
    end
  end

  assign overrun = r_overrun;

endmodule

// File: tb/tb_avfcl_acc_reader.sv
// Directed bench for avfcl_acc_reader: a vector table for burst/backpressure
// plus hand-written sequences for wrap, overrun, disable and reset corners.
module tb_avfcl_acc_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] epoch_len = '0;
  logic [24:0] iq_acc = '0, rob_acc = '0, lq_acc = '0, sq_acc = '0, ib_acc = '0, prf_acc = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [2:0]  out_id;
  logic [24:0] out_delta;
  logic [15:0] out_epoch;
  logic        out_last;
  logic        overrun;
  logic        busy;

  avfcl_acc_reader #(.ACC_W(25), .EPOCH_W(16), .EIDX_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .epoch_len(epoch_len),
    .iq_acc(iq_acc), .rob_acc(rob_acc), .lq_acc(lq_acc), .sq_acc(sq_acc),
    .ib_acc(ib_acc), .prf_acc(prf_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_delta(out_delta), .out_epoch(out_epoch), .out_last(out_last),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        exp_valid;
    logic [2:0]  exp_id;
    logic [24:0] exp_delta;
    logic [15:0] exp_epoch;
    logic        exp_last;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  vec_t        vt [12];
  logic [24:0] got_delta [6];
  logic [2:0]  got_id    [6];
  logic [15:0] got_epoch [6];
  logic        got_last  [6];
  logic        got_valid [6];
  logic [24:0] rec_delta [12];
  logic [2:0]  rec_id    [12];
  logic [15:0] rec_epoch [12];
  int          nrec;
  int          n;
  logic        saw_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; epoch_len = '0; out_ready = 1'b0;
    iq_acc = '0; rob_acc = '0; lq_acc = '0; sq_acc = '0; ib_acc = '0; prf_acc = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output int cycles);
    cycles = 0;
    while (!out_valid && cycles < bound) begin
      tick();
      cycles++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL wait_valid: no record within %0d cycles", bound);
    end
  endtask

  task automatic capture_burst();
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      got_valid[j] = out_valid;
      got_id[j]    = out_id;
      got_delta[j] = out_delta;
      got_epoch[j] = out_epoch;
      got_last[j]  = out_last;
      tick();
    end
  endtask

  initial begin
    // ready, valid, id, delta, epoch, last  (iq..prf = 1..6, epoch_len 20)
    vt[0]  = '{1'b1, 1'b1, 3'd0, 25'd1, 16'd0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 3'd1, 25'd2, 16'd0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 3'd2, 25'd3, 16'd0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 3'd2, 25'd3, 16'd0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 3'd2, 25'd3, 16'd0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 3'd2, 25'd3, 16'd0, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 3'd2, 25'd3, 16'd0, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 3'd3, 25'd4, 16'd0, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 3'd4, 25'd5, 16'd0, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 3'd5, 25'd6, 16'd0, 1'b1};
    vt[10] = '{1'b1, 1'b0, 3'd0, 25'd0, 16'd0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 3'd0, 25'd0, 16'd0, 1'b0};

    // Reset state
    do_reset();
    check("rst_valid", out_valid, 0);
    check("rst_id", out_id, 0);
    check("rst_delta", out_delta, 0);
    check("rst_epoch", out_epoch, 0);
    check("rst_last", out_last, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);

    // Basic burst: terminal on the 10th enabled edge, iq=100
    enable = 1'b1; epoch_len = 16'd10; out_ready = 1'b1; iq_acc = 25'd100;
    wait_valid(40, n);
    check("basic_latency", n, 10);
    capture_burst();
    for (int j = 0; j < 6; j++) begin
      check($sformatf("basic_valid%0d", j), got_valid[j], 1);
      check($sformatf("basic_id%0d", j), got_id[j], j);
      check($sformatf("basic_delta%0d", j), got_delta[j], (j == 0) ? 100 : 0);
      check($sformatf("basic_epoch%0d", j), got_epoch[j], 0);
      check($sformatf("basic_last%0d", j), got_last[j], (j == 5) ? 1 : 0);
    end
    check("basic_idle_after", out_valid, 0);
    check("basic_no_overrun", overrun, 0);

    // Backpressure via vector table
    do_reset();
    enable = 1'b1; epoch_len = 16'd20; out_ready = 1'b1;
    iq_acc = 25'd1; rob_acc = 25'd2; lq_acc = 25'd3; sq_acc = 25'd4; ib_acc = 25'd5; prf_acc = 25'd6;
    wait_valid(60, n);
    check("bp_latency", n, 20);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("vec%0d_valid", i), out_valid, vt[i].exp_valid);
      check($sformatf("vec%0d_busy", i), busy, vt[i].exp_valid);
      check($sformatf("vec%0d_id", i), out_id, vt[i].exp_id);
      check($sformatf("vec%0d_delta", i), out_delta, vt[i].exp_delta);
      check($sformatf("vec%0d_epoch", i), out_epoch, vt[i].exp_epoch);
      check($sformatf("vec%0d_last", i), out_last, vt[i].exp_last);
      out_ready = vt[i].ready;
      tick();
    end
    check("bp_no_overrun", overrun, 0);

    // Wrap-around of the modular subtract
    do_reset();
    enable = 1'b1; epoch_len = 16'd10; iq_acc = 25'h1FFFFF0;
    wait_valid(40, n);
    capture_burst();
    check("wrap_first_delta", got_delta[0], 32'h1FFFFF0);
    iq_acc = 25'h0000010;
    wait_valid(40, n);
    capture_burst();
    check("wrap_delta", got_delta[0], 32'h20);
    check("wrap_epoch", got_epoch[0], 1);

    // Overrun: epoch_len 4, ready low for 20 edges, rob +50 per epoch
    do_reset();
    enable = 1'b1; epoch_len = 16'd4;
    nrec = 0;
    for (int k = 0; k < 34; k++) begin
      rob_acc   = 25'(50 * (k / 4 + 1));
      out_ready = (k >= 20);
      if (out_valid && out_ready && nrec < 12) begin
        rec_id[nrec]    = out_id;
        rec_delta[nrec] = out_delta;
        rec_epoch[nrec] = out_epoch;
        nrec++;
      end
      tick();
    end
    check("ovr_records", nrec, 12);
    check("ovr_flag", overrun, 1);
    check("ovr_first_rob_delta", rec_delta[1], 50);
    check("ovr_first_epoch", rec_epoch[1], 0);
    check("ovr_second_iq_delta", rec_delta[6], 0);
    check("ovr_second_rob_id", rec_id[7], 1);
    check("ovr_second_rob_delta", rec_delta[7], 300);
    check("ovr_second_epoch", rec_epoch[7], 6);

    // Disable paths: epoch_len=0, then enable=0; counter must not move
    do_reset();
    saw_valid = 1'b0;
    enable = 1'b1; epoch_len = 16'd0; out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check("dis_len0_valid", saw_valid, 0);
    enable = 1'b0; epoch_len = 16'd10;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check("dis_en0_valid", saw_valid, 0);
    enable = 1'b1;
    wait_valid(40, n);
    check("dis_cnt_held", n, 10);

    // Reset mid-burst with overrun set
    do_reset();
    enable = 1'b1; epoch_len = 16'd4;
    iq_acc = 25'd11; rob_acc = 25'd22; lq_acc = 25'd33; sq_acc = 25'd44; ib_acc = 25'd55; prf_acc = 25'd66;
    for (int k = 0; k < 10; k++) tick();
    check("rmb_overrun_set", overrun, 1);
    out_ready = 1'b1;
    n = 0;
    while (!(out_valid && out_id == 3'd3) && n < 10) begin
      tick();
      n++;
    end
    check("rmb_reach_id3", out_id, 3);
    reset = 1'b1;
    tick();
    check("rmb_valid", out_valid, 0);
    check("rmb_overrun", overrun, 0);
    check("rmb_busy", busy, 0);
    reset = 1'b0; epoch_len = 16'd10;
    iq_acc = 25'd7; rob_acc = 25'd8; lq_acc = 25'd9; sq_acc = 25'd10; ib_acc = 25'd11; prf_acc = 25'd12;
    wait_valid(40, n);
    check("rmb_latency", n, 10);
    capture_burst();
    for (int j = 0; j < 6; j++)
      check($sformatf("rmb_delta%0d", j), got_delta[j], 7 + j);

    // Shortest safe epoch (7) versus one that collides with the id5 handshake (6)
    do_reset();
    enable = 1'b1; epoch_len = 16'd7; out_ready = 1'b1;
    for (int k = 0; k < 60; k++) tick();
    check("len7_no_overrun", overrun, 0);
    do_reset();
    enable = 1'b1; epoch_len = 16'd6; out_ready = 1'b1;
    for (int k = 0; k < 30; k++) tick();
    check("len6_overrun", overrun, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avfcl_acc_reader.md
# avfcl_acc_reader

Readout engine for the AVF cross-layer accumulators. It samples the six structure accumulators (IQ, ROB, LQ, SQ, IB, PRF) on a programmable epoch boundary and computes each one's modular growth since the previous sample. It streams the six deltas as tagged records over a valid/ready interface to the telemetry/export path. It is the consumer end of the accumulator outputs, and sits between the accumulator bank and the system trace buffer.

## Interface
Parameters:
- ACC_W, 25, width of every accumulator input and of each delta.
- EPOCH_W, 16, width of the epoch-length counter and of `epoch_len`.
- EIDX_W, 16, width of the epoch index carried on each record.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- enable  in  1  epoch counter advances only while high
- epoch_len  in  EPOCH_W  epoch length in cycles; 0 disables sampling
- iq_acc, rob_acc, lq_acc, sq_acc, ib_acc, prf_acc  in  ACC_W each  accumulator values, free-running, wrap modulo 2^ACC_W
- out_valid  out  1  record valid
- out_ready  in  1  consumer accepts record
- out_id  out  3  source: 0=IQ 1=ROB 2=LQ 3=SQ 4=IB 5=PRF
- out_delta  out  ACC_W  (sample − previous sample) mod 2^ACC_W
- out_epoch  out  EIDX_W  epoch index of the sample
- out_last  out  1  high on id 5 record
- overrun  out  1  sticky: an epoch boundary hit while a burst was still draining
- busy  out  1  burst in progress (state SEND)

## Operation
- Epoch counter `cnt` (EPOCH_W):
  - With enable=1 and epoch_len≠0: a terminal cycle occurs when cnt ≥ epoch_len−1; cnt goes to 0 and `epoch_idx` increments (wraps at 2^EIDX_W).
  - Otherwise cnt increments.
  - With enable=0 or epoch_len=0: cnt holds and no terminal cycle occurs.
- Registers: six `prev[i]`, six `delta[i]`, `idx` (0..5), `snap_epoch`.
- FSM IDLE:
  - On a terminal cycle: delta[i] ← acc[i] − prev[i] (ACC_W-bit modular subtract); prev[i] ← acc[i]; snap_epoch ← epoch_idx; idx ← 0; go to SEND.
- FSM SEND:
  - out_valid=1, out_id=idx, out_delta=delta[idx], out_epoch=snap_epoch, out_last=(idx==5).
  - On out_valid&&out_ready: if idx==5, go to IDLE; else idx+1.
- Terminal cycle while in SEND:
  - The sample is dropped and overrun ← 1.
  - prev is not updated, so the next accepted delta covers all dropped epochs and the sum of deltas stays exact.
  - epoch_idx still increments, so the consumer sees a gap in out_epoch.
- Terminal cycle in the same cycle as the final handshake (idx==5): the FSM is still in SEND, so this counts as an overrun drop.
- enable going low has no effect on an in-progress burst; the burst drains normally.
- overrun clears only on reset.

## Timing
- Reset values:
  - cnt=0, epoch_idx=0, prev=0, delta=0, idx=0, state IDLE.
  - out_valid=0, out_id=0, out_delta=0, out_epoch=0, out_last=0, overrun=0, busy=0.
- Inputs are sampled at the terminal-cycle clock edge. out_valid rises the following cycle with record id 0.
- Minimum burst length is 6 cycles (out_ready held high). A new burst can start on the cycle after the id-5 handshake.
- Minimum epoch_len that never overruns with ready held high: 7.
- While out_valid=1 and out_ready=0, all out_* fields stay stable.
- out_valid never drops without a handshake, except on reset.
- Reset asserted mid-burst: the burst is abandoned next cycle and every register returns to its reset value.
- epoch_len changes take effect at the next compare. If cnt already exceeds the new epoch_len−1, the very next enabled cycle is terminal.

## Test plan
- Basic burst:
  - Stimulus: reset; epoch_len=10; enable=1; out_ready=1; iq_acc=100, others 0 at the first terminal.
  - Response: terminal at cycle 9; six records id0..5 in cycles 10..15; id0 delta=100, rest 0; out_epoch=0; out_last only on id5.
- Wrap-around:
  - Stimulus: prev iq=0x1FFFFF0; next sample iq=0x0000010.
  - Response: iq delta=0x20.
- Backpressure:
  - Stimulus: out_ready=0 for 4 cycles while presenting id2.
  - Response: out_id=2 and out_delta held constant; id3 appears the cycle after out_ready=1.
- Overrun:
  - Stimulus: epoch_len=4; out_ready=0 throughout the first burst; rob_acc rises 50 per epoch.
  - Response: overrun=1; the next burst after release shows out_epoch skipping; rob delta = 50 × (number of epochs since last accepted sample).
- Disable paths:
  - Stimulus: epoch_len=0 for 100 cycles, then enable=0 for 100 cycles with epoch_len=10.
  - Response: out_valid stays 0; cnt holds.
- Reset mid-burst:
  - Stimulus: reset during id3.
  - Response: next cycle out_valid=0, overrun=0; the next burst's deltas equal the raw accumulator values, since prev=0.
